// File: rtl/taglist_builder.sv
// taglist_builder: scans sequence-ROM end markers and writes tag-list RAM entries.
// Define TAGLIST_RESTART_EN to decode flag 01 as restart-tag.
module taglist_builder #(
  parameter int ADDR_W   = 10,
  parameter int TAG_W    = 7,
  parameter int DATA_W   = 32,
  parameter int ROM_LAT  = 1,
  parameter int MAX_TAGS = 2**TAG_W-1
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [1:0]        rom_flag,
  output logic              ram_wr_en,
  output logic [TAG_W-1:0]  ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [TAG_W-1:0]  tag_count,
  output logic              error
);

  localparam int ENT_W = TAG_W + 2*ADDR_W + 1;
  localparam logic [TAG_W:0] MAX_SEQ = (TAG_W+1)'(MAX_TAGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t r_state, w_state;

  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr;
  logic              r_rd_vld, w_rd_vld;
  logic [ADDR_W-1:0] r_tag_start, w_tag_start;
  logic [TAG_W:0]    r_seq, w_seq;
  logic [TAG_W-1:0]  r_tag_count, w_tag_count;
  logic              r_error, w_error;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_wr_en, w_wr_en;
  logic [TAG_W-1:0]  r_wr_addr, w_wr_addr;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;

  // address delay line, aligned with rom_flag
  logic [ADDR_W-1:0] r_dl_addr [ROM_LAT];
  logic [ROM_LAT-1:0] r_dl_vld;

  logic              w_vld;
  logic [ADDR_W-1:0] w_a;
  logic              w_over;
  logic              w_last_a;
  logic              w_stop;
  logic              w_abort;
  logic [ENT_W-1:0]  w_entry;

  assign w_vld    = r_dl_vld[ROM_LAT-1];
  assign w_a      = r_dl_addr[ROM_LAT-1];
  assign w_over   = r_seq > MAX_SEQ;
  assign w_last_a = &w_a;
  assign w_entry  = {r_seq[TAG_W-1:0], r_tag_start, w_a, rom_flag[0]};

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n || r_state != S_SCAN || w_stop) begin
      r_dl_vld <= '0;
    end else begin
      r_dl_vld[0] <= r_rd_vld;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
      end
    end
    r_dl_addr[0] <= r_rom_addr;
    for (int i = 1; i < ROM_LAT; i++) begin
      r_dl_addr[i] <= r_dl_addr[i-1];
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_rd_vld    <= 1'b0;
      r_tag_start <= '0;
      r_seq       <= '0;
      r_tag_count <= '0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state;
      r_rom_addr  <= w_rom_addr;
      r_rd_vld    <= w_rd_vld;
      r_tag_start <= w_tag_start;
      r_seq       <= w_seq;
      r_tag_count <= w_tag_count;
      r_error     <= w_error;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_rom_addr  = r_rom_addr;
    w_rd_vld    = r_rd_vld;
    w_tag_start = r_tag_start;
    w_seq       = r_seq;
    w_tag_count = r_tag_count;
    w_error     = r_error;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_stop      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state     = S_SCAN;
          w_busy      = 1'b1;
          w_rom_addr  = '0;
          w_rd_vld    = 1'b1;
          w_tag_count = '0;
          w_error     = 1'b0;
          w_tag_start = '0;
          w_seq       = (TAG_W+1)'(1);
        end
      end
      S_SCAN: begin
        // hold at the top address rather than wrap
        if (r_rd_vld) begin
          if (&r_rom_addr) w_rd_vld = 1'b0;
          else w_rom_addr = r_rom_addr + 1'b1;
        end
        if (w_vld) begin
          if (rom_flag[1]) begin
            if (w_over) begin
              w_abort = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_wr_addr   = TAG_W'(r_seq - 1'b1);
              w_wr_data   = DATA_W'(w_entry);
              w_tag_count = r_tag_count + 1'b1;
              if (rom_flag[0]) begin
                w_stop = 1'b1;
              end else begin
                w_tag_start = w_a + 1'b1;
                w_seq       = r_seq + 1'b1;
              end
            end
          end else if (w_last_a) begin
            w_abort = 1'b1;
`ifdef TAGLIST_RESTART_EN
          end else if (rom_flag[0]) begin
            w_tag_start = w_a + 1'b1;
`endif
          end
        end
        if (w_abort) begin
          w_stop  = 1'b1;
          w_error = 1'b1;
        end
        if (w_stop) begin
          w_state  = S_DRAIN;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_rd_vld = 1'b0;
        end
      end
      S_DRAIN: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign rom_addr    = r_rom_addr;
  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tag_count   = r_tag_count;
  assign error       = r_error;

endmodule

// File: tb/tb_taglist_builder.sv
// Bench for taglist_builder: default instance plus a small
// instance (ADDR_W=6, TAG_W=3, ROM_LAT=3), checked against a scan model.
`timescale 1ns/1ps
module tb_taglist_builder;

`ifdef TAGLIST_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, start;

  logic [9:0]  a_rom_addr;
  logic [1:0]  a_rom_flag;
  logic        a_wr_en, a_busy, a_done, a_error;
  logic [6:0]  a_wr_addr, a_tag_count;
  logic [31:0] a_wr_data;

  logic [5:0]  b_rom_addr;
  logic [1:0]  b_rom_flag;
  logic        b_wr_en, b_busy, b_done, b_error;
  logic [2:0]  b_wr_addr, b_tag_count;
  logic [31:0] b_wr_data;

  taglist_builder u_a (
    .clk_50MHz(clk), .reset_n(rst_n), .start(start),
    .rom_addr(a_rom_addr), .rom_flag(a_rom_flag),
    .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr),
    .ram_wr_data(a_wr_data), .busy(a_busy), .done(a_done),
    .tag_count(a_tag_count), .error(a_error)
  );

  taglist_builder #(.ADDR_W(6), .TAG_W(3), .ROM_LAT(3)) u_b (
    .clk_50MHz(clk), .reset_n(rst_n), .start(start),
    .rom_addr(b_rom_addr), .rom_flag(b_rom_flag),
    .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr),
    .ram_wr_data(b_wr_data), .busy(b_busy), .done(b_done),
    .tag_count(b_tag_count), .error(b_error)
  );

  logic [1:0] rom [1024];
  logic [9:0] pa;
  logic [5:0] pb [3];

  always @(posedge clk) begin
    pa <= a_rom_addr;
    pb[0] <= b_rom_addr;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_rom_flag = rom[int'(pa)];
  assign b_rom_flag = rom[int'(pb[2])];

  typedef struct {
    int inst;
    int t;
    int addr;
    logic [31:0] data;
  } wr_t;

  wr_t qw[$];
  wr_t ex[$];
  int  dq_inst[$];
  int  dq_cyc[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wr_en) qw.push_back('{0, cyc, int'(a_wr_addr), a_wr_data});
    if (b_wr_en) qw.push_back('{1, cyc, int'(b_wr_addr), b_wr_data});
    if (a_done) begin dq_inst.push_back(0); dq_cyc.push_back(cyc); end
    if (b_done) begin dq_inst.push_back(1); dq_cyc.push_back(cyc); end
  end

  // Walks the ROM from address 0 applying the tag rules directly.
  task automatic model(input int k, input int t0, output int done_c,
                       output int cnt, output bit err);
    int aw, lat, maxt, st, seq, c;
    logic [1:0] f;
    aw = (k == 1) ? 6 : 10;
    lat = (k == 1) ? 3 : 1;
    maxt = (k == 1) ? 7 : 127;
    ex.delete();
    st = 0; seq = 1; cnt = 0; err = 1'b0; done_c = -1;
    for (int a = 0; a < (1 << aw); a++) begin
      f = rom[a];
      c = t0 + 2 + a + lat;
      if (f[1]) begin
        if (seq > maxt) begin err = 1'b1; done_c = c; break; end
        ex.push_back('{k, c, seq - 1, 32'((seq << (2*aw+1)) |
          (st << (aw+1)) | (a << 1) | int'(f[0]))});
        cnt++;
        if (f[0]) begin done_c = c; break; end
        st = a + 1;
        seq++;
      end else if (a == (1 << aw) - 1) begin
        err = 1'b1; done_c = c; break;
      end else if (RESTART && f == 2'b01) begin
        st = a + 1;
      end
    end
  endtask

  task automatic load_plan();
    for (int i = 0; i < 1024; i++) rom[i] = 2'b00;
    rom[5] = 2'b10; rom[9] = 2'b10; rom[12] = 2'b10; rom[17] = 2'b11;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_rom_addr, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_done,
         a_tag_count, a_error} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got busy=%b err=%b cnt=%0d addr=%0d",
               a_busy, a_error, a_tag_count, a_rom_addr);
    end
    n_cmp++;
    if ({b_rom_addr, b_wr_en, b_wr_addr, b_wr_data, b_busy, b_done,
         b_tag_count, b_error} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got busy=%b err=%b cnt=%0d addr=%0d",
               b_busy, b_error, b_tag_count, b_rom_addr);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start: busy a=%b b=%b, expected 0 0", a_busy, b_busy);
    end
  endtask

  task automatic test_abort_reset();
    int n;
    load_plan();
    qw.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (qw.size() == 0 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (qw.size() == 0) begin
      n_bad++;
      $display("FAIL abort_first_write: no write within %0d cycles", n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    qw.delete(); dq_inst.delete(); dq_cyc.delete();
    n_cmp++;
    if ({a_wr_en, a_busy, a_done, a_tag_count, a_error,
         b_wr_en, b_busy, b_done, b_tag_count, b_error} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset_outs: busy a=%b b=%b cnt a=%0d b=%0d",
               a_busy, b_busy, a_tag_count, b_tag_count);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (qw.size() != 0 || dq_cyc.size() != 0 || a_busy || b_busy) begin
      n_bad++;
      $display("FAIL abort_stale: writes=%0d dones=%0d, expected 0 0",
               qw.size(), dq_cyc.size());
    end
  endtask

  task automatic test_scans();
    int t0, dc, cnt, j, nd, dcy, tc, n, r;
    bit err, er, bz;
    for (int sc = 0; sc < 25; sc++) begin
      for (int i = 0; i < 1024; i++) rom[i] = 2'b00;
      case (sc)
        0: load_plan();
        1: rom[0] = 2'b11;
        2: for (int i = 0; i < 1024; i++) rom[i] = 2'b10;
        3: ;
        4: begin rom[3] = 2'b01; rom[5] = 2'b10; rom[8] = 2'b11; end
        default:
          for (int i = 0; i < 1024; i++) begin
            r = int'($urandom_range(0, 99));
            rom[i] = (r < 8) ? 2'b10 : (r < 11) ? 2'b11 :
                     (r < 16) ? 2'b01 : 2'b00;
          end
      endcase
      qw.delete(); dq_inst.delete(); dq_cyc.delete();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t0 = cyc - 1;
      n_cmp++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1 || a_rom_addr !== 10'd0) begin
        n_bad++;
        $display("FAIL scan%0d_busy: busy a=%b b=%b addr=%0d, expected 1 1 0",
                 sc, a_busy, b_busy, a_rom_addr);
      end
      n = 0;
      while (dq_cyc.size() < 2 && n < 1500) begin
        @(negedge clk);
        n++;
        if ((sc == 0 || sc == 3) && n == 4) begin
          start = 1'b1;
          @(posedge clk); #1; start = 1'b0;
        end
      end
      n_cmp++;
      if (dq_cyc.size() < 2) begin
        n_bad++;
        $display("FAIL scan%0d_timeout: dones=%0d after %0d cycles, expected 2",
                 sc, dq_cyc.size(), n);
      end
      repeat (6) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        model(k, t0, dc, cnt, err);
        j = 0;
        foreach (qw[i]) begin
          if (qw[i].inst == k) begin
            n_cmp++;
            if (j >= ex.size()) begin
              n_bad++;
              $display("FAIL scan%0d_extra%0d: write cyc=%0d addr=%0d data=%h, expected none",
                       sc, k, qw[i].t - t0, qw[i].addr, qw[i].data);
            end else if (qw[i].t != ex[j].t || qw[i].addr != ex[j].addr ||
                         qw[i].data !== ex[j].data) begin
              n_bad++;
              $display("FAIL scan%0d_wr%0d_%0d: got cyc=%0d addr=%0d data=%h, expected cyc=%0d addr=%0d data=%h",
                       sc, k, j, qw[i].t - t0, qw[i].addr, qw[i].data,
                       ex[j].t - t0, ex[j].addr, ex[j].data);
            end
            j++;
          end
        end
        n_cmp++;
        if (j != ex.size()) begin
          n_bad++;
          $display("FAIL scan%0d_nwr%0d: got %0d writes, expected %0d",
                   sc, k, j, ex.size());
        end
        nd = 0; dcy = -1;
        foreach (dq_cyc[i]) begin
          if (dq_inst[i] == k) begin nd++; dcy = dq_cyc[i]; end
        end
        n_cmp++;
        if (nd != 1 || dcy != dc) begin
          n_bad++;
          $display("FAIL scan%0d_done%0d: got %0d pulses last cyc=%0d, expected 1 at cyc=%0d",
                   sc, k, nd, dcy - t0, dc - t0);
        end
        tc = (k == 1) ? int'(b_tag_count) : int'(a_tag_count);
        er = (k == 1) ? b_error : a_error;
        bz = (k == 1) ? b_busy : a_busy;
        n_cmp++;
        if (tc != cnt || er !== err || bz !== 1'b0) begin
          n_bad++;
          $display("FAIL scan%0d_status%0d: got count=%0d err=%b busy=%b, expected %0d %b 0",
                   sc, k, tc, er, bz, cnt, err);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 2'b00;
    test_reset();
    test_abort_reset();
    test_scans();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
